// File: rtl/vending_controller_param.sv
// Single-product vending controller.
// Accumulates 5/10/25c coin pulses up to MAX_CREDIT, vends once credit reaches PRICE,
// then pays change greedily (25/10/5) one coin per valid/ready handshake to the hopper.
// Adds cancel, inactivity refund, overflow rejection and hopper back-pressure.
//
// Ports:
//   clk_i          clock, rising edge
//   rst_ni         asynchronous active-low reset
//   c5_i/c10_i/c25_i single-cycle coin pulses (edge-detected upstream)
//   cancel_i       single-cycle refund request (honoured in COLLECT only)
//   item_taken_i   level, customer removed the item
//   chg_ready_i    hopper accepts the presented change coin
//   dispense_o     item-release level
//   chg_valid_o    change coin presented
//   chg_coin_o     00 none, 01 5c, 10 10c, 11 25c
//   credit_o       credit in cents; remaining change while paying out
//   coin_reject_o  one-cycle pulse, return the physical coin
//   busy_o         high while vending or paying change
module vending_controller_param #(
  parameter int unsigned PRICE       = 35,
  parameter int unsigned MAX_CREDIT  = 95,
  parameter int unsigned AMT_W       = 8,
  parameter int unsigned TIMEOUT_CYC = 100_000_000
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             c5_i,
  input  logic             c10_i,
  input  logic             c25_i,
  input  logic             cancel_i,
  input  logic             item_taken_i,
  input  logic             chg_ready_i,
  output logic             dispense_o,
  output logic             chg_valid_o,
  output logic [1:0]       chg_coin_o,
  output logic [AMT_W-1:0] credit_o,
  output logic             coin_reject_o,
  output logic             busy_o
);

  localparam int unsigned SumW = AMT_W + 1;

  typedef logic [AMT_W-1:0] amt_t;
  typedef logic [SumW-1:0]  sum_t;

  localparam sum_t        PriceS  = sum_t'(PRICE);
  localparam sum_t        MaxS    = sum_t'(MAX_CREDIT);
  localparam logic [31:0] TmrLast = 32'(TIMEOUT_CYC - 1);

  localparam logic [1:0] CoinNone = 2'b00;
  localparam logic [1:0] Coin5    = 2'b01;
  localparam logic [1:0] Coin10   = 2'b10;
  localparam logic [1:0] Coin25   = 2'b11;

  typedef enum logic [1:0] {StIdle, StCollect, StVend, StChange} state_e;

  state_e      state_q, state_d;
  amt_t        credit_q, credit_d;
  amt_t        change_q, change_d;
  logic [31:0] tmr_q, tmr_d;
  logic        dispense_q, dispense_d;
  logic        chg_valid_q, chg_valid_d;
  logic [1:0]  chg_coin_q, chg_coin_d;
  logic        coin_reject_q, coin_reject_d;
  logic        busy_q, busy_d;

  logic        coin_any, coin_multi, refund;
  sum_t        coin_val, sum;
  amt_t        rem;

  // Largest coin not exceeding the amount; amounts are always multiples of 5.
  function automatic logic [1:0] greedy_code(input amt_t amt);
    if (amt >= amt_t'(25)) begin
      return Coin25;
    end else if (amt >= amt_t'(10)) begin
      return Coin10;
    end else begin
      return Coin5;
    end
  endfunction

  function automatic amt_t code_value(input logic [1:0] code);
    case (code)
      Coin5:   return amt_t'(5);
      Coin10:  return amt_t'(10);
      Coin25:  return amt_t'(25);
      default: return amt_t'(0);
    endcase
  endfunction

  always_comb begin
    coin_any   = c5_i | c10_i | c25_i;
    coin_multi = (c5_i & c10_i) | (c5_i & c25_i) | (c10_i & c25_i);
    if (c25_i) begin
      coin_val = sum_t'(25);
    end else if (c10_i) begin
      coin_val = sum_t'(10);
    end else if (c5_i) begin
      coin_val = sum_t'(5);
    end else begin
      coin_val = '0;
    end
    sum    = {1'b0, credit_q} + coin_val;
    // Inactivity timeout is treated exactly like a cancel.
    refund = (state_q == StCollect) && (cancel_i || (tmr_q == TmrLast));
  end

  always_comb begin
    state_d       = state_q;
    credit_d      = credit_q;
    change_d      = change_q;
    tmr_d         = tmr_q;
    dispense_d    = dispense_q;
    chg_valid_d   = chg_valid_q;
    chg_coin_d    = chg_coin_q;
    coin_reject_d = 1'b0;
    rem           = '0;

    unique case (state_q)
      StIdle, StCollect: begin
        if (state_q == StCollect) begin
          tmr_d = tmr_q + 32'd1;
        end
        if (refund) begin
          // Cancel beats a coin arriving in the same cycle.
          coin_reject_d = coin_any;
          state_d       = StChange;
          chg_valid_d   = 1'b1;
          chg_coin_d    = greedy_code(credit_q);
          tmr_d         = '0;
        end else if (coin_any) begin
          coin_reject_d = coin_multi;
          if (sum > MaxS) begin
            coin_reject_d = 1'b1;
          end else begin
            credit_d = sum[AMT_W-1:0];
            tmr_d    = '0;
            if (sum < PriceS) begin
              state_d = StCollect;
            end else begin
              state_d    = StVend;
              change_d   = amt_t'(sum - PriceS);
              dispense_d = 1'b1;
            end
          end
        end
      end

      StVend: begin
        coin_reject_d = coin_any;
        if (item_taken_i) begin
          dispense_d = 1'b0;
          change_d   = '0;
          if (change_q != '0) begin
            state_d     = StChange;
            credit_d    = change_q;
            chg_valid_d = 1'b1;
            chg_coin_d  = greedy_code(change_q);
          end else begin
            state_d  = StIdle;
            credit_d = '0;
          end
        end
      end

      StChange: begin
        coin_reject_d = coin_any;
        // credit_q holds the change still owed while in this state.
        if (chg_valid_q && chg_ready_i) begin
          rem = credit_q - code_value(chg_coin_q);
          if (rem == '0) begin
            state_d     = StIdle;
            credit_d    = '0;
            chg_valid_d = 1'b0;
            chg_coin_d  = CoinNone;
          end else begin
            credit_d   = rem;
            chg_coin_d = greedy_code(rem);
          end
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase

    busy_d = (state_d == StVend) || (state_d == StChange);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= StIdle;
      credit_q      <= '0;
      change_q      <= '0;
      tmr_q         <= '0;
      dispense_q    <= 1'b0;
      chg_valid_q   <= 1'b0;
      chg_coin_q    <= CoinNone;
      coin_reject_q <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      credit_q      <= credit_d;
      change_q      <= change_d;
      tmr_q         <= tmr_d;
      dispense_q    <= dispense_d;
      chg_valid_q   <= chg_valid_d;
      chg_coin_q    <= chg_coin_d;
      coin_reject_q <= coin_reject_d;
      busy_q        <= busy_d;
    end
  end

  assign dispense_o    = dispense_q;
  assign chg_valid_o   = chg_valid_q;
  assign chg_coin_o    = chg_coin_q;
  assign credit_o      = credit_q;
  assign coin_reject_o = coin_reject_q;
  assign busy_o        = busy_q;

endmodule
